// File: rtl/sqrt_in_feeder.sv
// sqrt_in_feeder: small circular FIFO in front of the Sqrt2 root stage.
// Operands arrive in bursts and leave one at a time, each held on
// out_data for at least PACE cycles so the root stage can settle.
// out_valid strobes for one cycle when a fresh operand is presented.
module sqrt_in_feeder #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8,
    parameter int PACE  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     enable,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // A PACE of 1 still needs a one-bit counter that simply sits at zero.
    localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
    localparam logic [PW-1:0] PACE_TOP = PW'(PACE - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [PW-1:0]    pace_cnt;
    logic             wr_go;
    logic             rel_go;
    logic [CW-1:0]    count_nxt;

    // Pacer advance: climbs toward PACE-1 and parks there until a release.
    function automatic logic [PW-1:0] pace_sat_inc(input logic [PW-1:0] cur);
        return (cur == PACE_TOP) ? cur : cur + 1'b1;
    endfunction

    // Accept/release decisions are made from registered full/empty only,
    // so a full FIFO drops a write even when a release frees a slot on the
    // same edge, and an empty FIFO never releases the operand being written.
    always_comb begin
        wr_go     = wr_en && !full;
        rel_go    = enable && (pace_cnt == PACE_TOP) && !empty;
        count_nxt = count;
        if (wr_go && !rel_go)
            count_nxt = count + CNT_ONE;
        else if (rel_go && !wr_go)
            count_nxt = count - CNT_ONE;
    end

    // Operand storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (wr_go)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy flags, sticky overflow and pacer state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            pace_cnt <= '0;
        end else begin
            if (wr_go)
                wr_ptr <= wr_ptr + 1'b1;
            if (rel_go)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full)
                overflow <= 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
            if (rel_go)
                pace_cnt <= '0;
            else if (enable)
                pace_cnt <= pace_sat_inc(pace_cnt);
        end
    end

    // Output stage: head operand latched on release and held until the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rel_go;
            if (rel_go)
                out_data <= mem[rd_ptr];
        end
    end

endmodule

// File: doc/sqrt_in_feeder.md
# sqrt_in_feeder

Paced input buffer sitting directly upstream of the `Sqrt2` square-root stage. It accepts 15-bit operands in bursts, stores them in a small FIFO, and releases one operand at a time onto `Sqrt2`'s `In` bus. Each released operand is held stable for at least `PACE` cycles, giving the root stage settle time between operands. A one-cycle strobe marks each new operand so the downstream capture logic knows when a fresh result is due.

## Interface
Parameters:
- `WIDTH`, 15, operand width; matches `Sqrt2` `In`.
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `PACE`, 4, minimum cycles between successive releases; ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `wr_en`  in  1  write request for `wr_data`.
- `wr_data`  in  WIDTH  operand to enqueue.
- `enable`  in  1  pacer run; low freezes releases.
- `out_data`  out  WIDTH  held operand; drives `Sqrt2` `In`.
- `out_valid`  out  1  high for exactly one cycle after each release.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; set on a dropped write.

## Operation
- Reset values: `out_data`=0, `out_valid`=0, `count`=0, `full`=0, `empty`=1, `overflow`=0. Read/write pointers and `pace_cnt` reset to 0.
- Storage is a circular buffer with `$clog2(DEPTH)`-bit pointers that wrap from DEPTH-1 to 0.
- **Write:**
  - When `wr_en` is high and registered `full` is 0, `wr_data` is stored at the write pointer and the pointer advances.
  - When `wr_en` is high and `full` is 1, the data is dropped and `overflow` is set to 1.
  - This holds even if a release happens on the same edge; there is no write-through when full.
  - `overflow` clears only on `reset`.
- **Pacer:**
  - While `enable` is high, `pace_cnt` increments each cycle and saturates at PACE-1.
  - While `enable` is low, `pace_cnt` holds and no release occurs.
- **Release:**
  - A release happens on an edge where `enable`=1, `pace_cnt`=PACE-1 and registered `empty`=0.
  - On release, `out_data` takes the head entry, the read pointer advances, `out_valid` is set for one cycle, and `pace_cnt` goes to 0.
  - If `pace_cnt` is saturated and the FIFO is empty, the counter waits there. The release fires on the first edge with `empty`=0.
- **Empty bypass:** none. A write into an empty FIFO cannot be released on the same edge; `empty` is evaluated from registered state.
- **Count update:** +1 on write only, −1 on release only, unchanged when both happen. `full` and `empty` are registered alongside `count`.
- `out_data` holds its value between releases. It is never cleared except by reset.
- **Reset mid-operation:** buffered contents are discarded immediately and all outputs return to their reset values. Operation resumes on the first edge after `reset` falls.

## Timing
- Write latency: data written on edge N is reflected in `count`/`empty` after edge N. The earliest release is edge N+1.
- Release cadence: with data continuously available and `enable`=1, releases occur every PACE edges (PACE=1 gives one release per cycle).
- After reset with `enable`=1, `pace_cnt` reaches PACE-1 after PACE-1 edges. The first release can therefore be no earlier than edge PACE.
- `out_valid` rises after the release edge and falls after the next edge.
- `out_data` changes only on release edges or reset.

## Test plan
- **Reset:** assert `reset` mid-cycle with the FIFO holding 3 entries. All outputs go to their reset values asynchronously (`empty`=1, `count`=0). After release, no stale data appears.
- **Single operand** (PACE=4, `enable`=1 from reset deassert): write 0x1234 on edge 1. After edge 4, `out_data`=0x1234 and `out_valid`=1 for one cycle. `count` is 1 after edge 1 and 0 after edge 4.
- **Fill and overflow** (`enable`=0): write 0x0001..0x0008. After the 8th write, `full`=1 and `count`=8. A 9th write of 0x0009 leaves `count`=8 and sets `overflow`=1. Raising `enable` then releases 0x0001..0x0008 in order, every 4 cycles; 0x0009 never appears.
- **Simultaneous write and release at full:** with `count`=8, drive `wr_en` on the release edge. The write is dropped, `overflow`=1, `count`=7. Wrap-around check: after writing into the slot freed by the release, the next 8 releases come out in FIFO order across the pointer wrap.
- **Pacer freeze:** with 2 entries queued and `pace_cnt`=2, drop `enable` for 5 cycles. There is no release and `out_data` is held. Re-raising `enable` gives a release on the second edge after, then the next release 4 edges later.
- **Empty wait:** let the FIFO drain and idle for 10 cycles with `enable`=1. Write 0x7FFF on edge M. The release occurs at edge M+1 and `out_data`=0x7FFF.
